cpu_selftest: RTL and testbench

Synthesizable on-FPGA self-test sequencer for the MIPS core. It runs one test program per `start`:
- loads a parametrised program into instruction memory through a write port while the CPU is held in reset;
- releases the CPU for a fixed number of cycles, then freezes it;
- walks a table of expected register-file and data-memory values through debug read ports.

It sits beside `cpu` at the FPGA top level and reports pass/fail plus first-failure details.

---
 rtl/cpu_selftest_pkg.sv | 30 +++
 rtl/cpu_selftest_if.sv | 43 ++++
 rtl/selftest_checker.sv | 69 ++++++
 rtl/cpu_selftest.sv | 154 +++++++++++++++
 tb/tb_cpu_selftest.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_selftest_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_selftest_pkg
// Purpose  : Shared types and constants for the CPU self-test sequencer:
//            sequencer state encoding, check-kind codes and HOLD length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_selftest_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HOLD  = 3'd2,
        RUN   = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic CHECK_REG   = 1'b0;
    localparam logic CHECK_MEM   = 1'b1;
    localparam int   HOLD_CYCLES = 2;

    // States in which a test sequence is in flight and start is ignored.
    function automatic logic state_is_busy(input state_t s);
        return (s == LOAD) || (s == HOLD) || (s == RUN) || (s == CHECK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_selftest_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_selftest_if
// Purpose  : Bus bundle between the self-test sequencer and its environment:
//            program ROM read, instruction-memory write port, check-table
//            read and the combinational debug read ports of the CPU.
// Modports : master - sequencer side (drives addresses / write port)
//            slave  - environment side (returns ROM, table and debug data)
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_selftest_if #(
    parameter int IMEM_AW = 8,
    parameter int CHK_W   = 4
);
    logic [IMEM_AW-1:0] prog_index;
    logic [31:0]        prog_word;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;
    logic [CHK_W-1:0]   chk_index;
    logic               chk_kind;
    logic [31:0]        chk_addr;
    logic [31:0]        chk_expected;
    logic [4:0]         dbg_reg_addr;
    logic [31:0]        dbg_reg_data;
    logic [31:0]        dbg_mem_addr;
    logic [31:0]        dbg_mem_data;

    modport master (
        output prog_index, imem_we, imem_waddr, imem_wdata,
               chk_index, dbg_reg_addr, dbg_mem_addr,
        input  prog_word, chk_kind, chk_addr, chk_expected,
               dbg_reg_data, dbg_mem_data
    );

    modport slave (
        input  prog_index, imem_we, imem_waddr, imem_wdata,
               chk_index, dbg_reg_addr, dbg_mem_addr,
        output prog_word, chk_kind, chk_addr, chk_expected,
               dbg_reg_data, dbg_mem_data
    );
endinterface
`default_nettype wire

// File: rtl/selftest_checker.sv
`default_nettype none
// ============================================================================
// Module   : selftest_checker
// Purpose  : Compares one observed value per valid cycle against its expected
//            value; keeps a saturating mismatch count and captures the index
//            and observed value of the first mismatch.
// Ports    : clock, reset_n      - clock / async active-low reset
//            clear               - synchronous clear of all results
//            valid, index        - compare strobe and check-table index
//            expected, observed  - values under comparison
//            mismatch            - combinational compare result this cycle
//            fail_count, first_fail_index, first_fail_observed - results
// Revision : 1.0 - initial release
// ============================================================================
module selftest_checker
    import cpu_selftest_pkg::*;
#(
    parameter int CHK_W      = 4,
    parameter int NUM_CHECKS = 4
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    input  wire logic             clear,
    input  wire logic             valid,
    input  wire logic [CHK_W-1:0] index,
    input  wire logic [31:0]      expected,
    input  wire logic [31:0]      observed,
    output logic                  mismatch,
    output logic [CHK_W:0]        fail_count,
    output logic [CHK_W-1:0]      first_fail_index,
    output logic [31:0]           first_fail_observed
);

    localparam logic [CHK_W:0] c_fail_max = (CHK_W+1)'(NUM_CHECKS);
    localparam logic [CHK_W:0] c_one      = (CHK_W+1)'(1);

    logic [CHK_W:0]   r_fail_count;
    logic [CHK_W-1:0] r_first_idx;
    logic [31:0]      r_first_obs;

    assign mismatch = valid && (observed != expected);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fail_count <= '0;
            r_first_idx  <= '0;
            r_first_obs  <= '0;
        end else if (clear) begin
            r_fail_count <= '0;
            r_first_idx  <= '0;
            r_first_obs  <= '0;
        end else if (mismatch) begin
            if (r_fail_count != c_fail_max) begin
                r_fail_count <= r_fail_count + c_one;
            end
            // A zero count means no earlier mismatch in this run.
            if (r_fail_count == '0) begin
                r_first_idx <= index;
                r_first_obs <= observed;
            end
        end
    end

    assign fail_count          = r_fail_count;
    assign first_fail_index    = r_first_idx;
    assign first_fail_observed = r_first_obs;

endmodule
`default_nettype wire

// File: rtl/cpu_selftest.sv
`default_nettype none
// ============================================================================
// Module   : cpu_selftest
// Purpose  : On-FPGA self-test sequencer for the MIPS core. Per start it
//            loads a program into instruction memory with the CPU in reset,
//            releases the CPU for RUN_CYCLES cycles, freezes it, then walks
//            the expected-value table through the debug read ports.
// Ports    : clock, reset_n  - clock / async active-low reset
//            start           - one-cycle request (IDLE or DONE only)
//            bus             - ROM / imem write / check table / debug reads
//            cpu_reset       - active-high reset to the CPU
//            busy, done, pass, fail_count, first_fail_index,
//            first_fail_observed - status and results
// Revision : 1.0 - initial release
// ============================================================================
module cpu_selftest
    import cpu_selftest_pkg::*;
#(
    parameter int NUM_INSTR  = 16,
    parameter int NUM_CHECKS = 4,
    parameter int RUN_CYCLES = 32,
    parameter int IMEM_AW    = 8,
    parameter int CHK_W      = 4
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    input  wire logic        start,
    cpu_selftest_if.master   bus,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CHK_W:0]   fail_count,
    output logic [CHK_W-1:0] first_fail_index,
    output logic [31:0]      first_fail_observed
);

    localparam int                 c_cnt_w      = $clog2(RUN_CYCLES + HOLD_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_run_last   = c_cnt_w'(RUN_CYCLES - 1);
    localparam logic [IMEM_AW-1:0] c_last_instr = IMEM_AW'(NUM_INSTR - 1);
    localparam logic [CHK_W-1:0]   c_last_check = CHK_W'(NUM_CHECKS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [IMEM_AW-1:0]   r_load_idx;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [CHK_W-1:0]     r_chk_idx;
    logic                 r_cpu_reset;
    logic                 r_busy;
    logic                 r_imem_we;
    logic                 r_done;
    logic                 r_pass;
    logic                 w_cpu_reset_nxt;
    logic                 w_busy_nxt;
    logic                 w_imem_we_nxt;
    logic                 w_done_nxt;
    logic                 w_start_ok;
    logic                 w_check_valid;
    logic                 w_mismatch;
    logic [31:0]          w_observed;

    assign w_start_ok    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_check_valid = (r_state == CHECK);

    // ---------------- state register (plus registered outputs/counters) ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_load_idx  <= '0;
            r_cnt       <= '0;
            r_chk_idx   <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_imem_we   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cpu_reset <= w_cpu_reset_nxt;
            r_busy      <= w_busy_nxt;
            r_imem_we   <= w_imem_we_nxt;
            r_done      <= w_done_nxt;
            // Counters run while their state persists and restart at zero on
            // every state change, so each phase begins with index 0.
            r_load_idx  <= (r_state == LOAD && w_next == LOAD) ? r_load_idx + 1'b1 : '0;
            r_cnt       <= ((r_state == HOLD || r_state == RUN) && w_next == r_state)
                           ? r_cnt + 1'b1 : '0;
            r_chk_idx   <= (r_state == CHECK && w_next == CHECK) ? r_chk_idx + 1'b1 : '0;
            // The last compare lands on the same edge as DONE entry, so the
            // verdict folds in this cycle's mismatch rather than waiting.
            if (w_start_ok) begin
                r_pass <= 1'b0;
            end else if (r_state == CHECK && w_next == DONE) begin
                r_pass <= (fail_count == '0) && !w_mismatch;
            end
        end
    end

    // ---------------- next-state logic -------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start)                      w_next = LOAD;
            LOAD:       if (r_load_idx == c_last_instr) w_next = HOLD;
            HOLD:       if (r_cnt == c_hold_last)       w_next = RUN;
            RUN:        if (r_cnt == c_run_last)        w_next = CHECK;
            CHECK:      if (r_chk_idx == c_last_check)  w_next = DONE;
            default:                                    w_next = IDLE;
        endcase
    end

    // ---------------- output logic (decoded from next state) ---------------
    always_comb begin
        w_cpu_reset_nxt = (w_next != RUN);
        w_busy_nxt      = state_is_busy(w_next);
        w_imem_we_nxt   = (w_next == LOAD);
        w_done_nxt      = (w_next == DONE);
    end

    // ---------------- bus mux paths ----------------------------------------
    assign bus.prog_index   = r_load_idx;
    assign bus.imem_we      = r_imem_we;
    assign bus.imem_waddr   = r_load_idx;
    assign bus.imem_wdata   = r_imem_we ? bus.prog_word : '0;
    assign bus.chk_index    = r_chk_idx;
    assign bus.dbg_reg_addr = (w_check_valid && bus.chk_kind == CHECK_REG) ? bus.chk_addr[4:0] : '0;
    assign bus.dbg_mem_addr = (w_check_valid && bus.chk_kind == CHECK_MEM) ? bus.chk_addr : '0;
    assign w_observed       = (bus.chk_kind == CHECK_MEM) ? bus.dbg_mem_data : bus.dbg_reg_data;

    selftest_checker #(
        .CHK_W      (CHK_W),
        .NUM_CHECKS (NUM_CHECKS)
    ) u_checker (
        .clock               (clock),
        .reset_n             (reset_n),
        .clear               (w_start_ok),
        .valid               (w_check_valid),
        .index               (r_chk_idx),
        .expected            (bus.chk_expected),
        .observed            (w_observed),
        .mismatch            (w_mismatch),
        .fail_count          (fail_count),
        .first_fail_index    (first_fail_index),
        .first_fail_observed (first_fail_observed)
    );

    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_cpu_selftest.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_selftest
// Purpose  : Self-checking bench for cpu_selftest. Provides the program ROM,
//            check table and a tiny MIPS subset model (addi/beq/bne/sw/lw)
//            that executes from the instruction memory the DUT loads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_selftest;

    localparam int NUM_INSTR  = 11;
    localparam int NUM_CHECKS = 3;
    localparam int RUN_CYCLES = 40;
    localparam int IMEM_AW    = 8;
    localparam int CHK_W      = 2;
    // Cycle (counted from the start-sampling edge) in which done rises.
    localparam int DONE_AT    = NUM_INSTR + 3 + RUN_CYCLES + NUM_CHECKS;

    logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic cpu_reset, busy, done, pass;
    logic [CHK_W:0]   fail_count;
    logic [CHK_W-1:0] first_fail_index;
    logic [31:0]      first_fail_observed;

    cpu_selftest_if #(.IMEM_AW(IMEM_AW), .CHK_W(CHK_W)) bus ();

    cpu_selftest #(
        .NUM_INSTR(NUM_INSTR), .NUM_CHECKS(NUM_CHECKS), .RUN_CYCLES(RUN_CYCLES),
        .IMEM_AW(IMEM_AW), .CHK_W(CHK_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .bus(bus),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_index(first_fail_index),
        .first_fail_observed(first_fail_observed)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- environment: ROM, check table, CPU model -------------
    logic [31:0] rom [0:255];
    logic        tbl_kind [0:3];
    logic [31:0] tbl_addr [0:3];
    logic [31:0] tbl_exp  [0:3];
    logic [31:0] regs [0:31];
    logic [31:0] dmem [0:255];
    logic [31:0] imem [0:255];
    logic [7:0]  pc;
    logic        model_clear = 1'b0;
    logic [31:0] instr, simm, ea;
    logic [7:0]  npc;

    assign bus.prog_word    = rom[bus.prog_index];
    assign bus.chk_kind     = tbl_kind[bus.chk_index];
    assign bus.chk_addr     = tbl_addr[bus.chk_index];
    assign bus.chk_expected = tbl_exp[bus.chk_index];
    assign bus.dbg_reg_data = regs[bus.dbg_reg_addr];
    assign bus.dbg_mem_data = dmem[bus.dbg_mem_addr[7:0]];

    always @(posedge clock) begin
        if (model_clear) begin
            for (int i = 0; i < 32; i++)  regs[i] <= '0;
            for (int i = 0; i < 256; i++) dmem[i] <= '0;
            pc <= '0;
        end else begin
            if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
            if (cpu_reset) begin
                pc <= '0;
            end else begin
                instr = imem[pc];
                simm  = {{16{instr[15]}}, instr[15:0]};
                ea    = regs[instr[25:21]] + simm;
                npc   = pc + 8'd1;
                case (instr[31:26])
                    6'h08: if (instr[20:16] != 5'd0) regs[instr[20:16]] <= ea;
                    6'h04: if (regs[instr[25:21]] == regs[instr[20:16]]) npc = pc + 8'd1 + simm[7:0];
                    6'h05: if (regs[instr[25:21]] != regs[instr[20:16]]) npc = pc + 8'd1 + simm[7:0];
                    6'h2b: dmem[ea[9:2]] <= regs[instr[20:16]];
                    6'h23: if (instr[20:16] != 5'd0) regs[instr[20:16]] <= dmem[ea[9:2]];
                    default: ;
                endcase
                pc <= npc;
            end
        end
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic load_branch_program();
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0]  = itype(6'h08, 5'd0, 5'd8, 16'd1);      // addi t0,zero,1
        rom[1]  = itype(6'h08, 5'd0, 5'd9, 16'd2);      // addi t1,zero,2
        rom[2]  = itype(6'h04, 5'd8, 5'd9, 16'd2);      // beq  t0,t1,+2 (not taken)
        rom[3]  = itype(6'h08, 5'd8, 5'd8, 16'd3);      // addi t0,t0,3  -> 4
        rom[4]  = itype(6'h05, 5'd8, 5'd9, 16'd1);      // bne  t0,t1,+1 (taken)
        rom[5]  = itype(6'h08, 5'd0, 5'd8, 16'd99);     // skipped
        rom[6]  = itype(6'h08, 5'd9, 5'd9, 16'd4);      // addi t1,t1,4  -> 6
        rom[7]  = itype(6'h04, 5'd0, 5'd0, 16'd1);      // beq  zero,zero,+1
        rom[8]  = itype(6'h08, 5'd0, 5'd9, 16'd77);     // skipped
        rom[9]  = 32'h0000_0000;                        // nop
        rom[10] = itype(6'h04, 5'd0, 5'd0, 16'hffff);   // halt loop
        tbl_kind[0] = 1'b0; tbl_addr[0] = 32'd8; tbl_exp[0] = 32'd4;
        tbl_kind[1] = 1'b0; tbl_addr[1] = 32'd9; tbl_exp[1] = 32'd6;
        tbl_kind[2] = 1'b1; tbl_addr[2] = 32'd0; tbl_exp[2] = 32'd0;
        tbl_kind[3] = 1'b0; tbl_addr[3] = 32'd0; tbl_exp[3] = 32'd0;
    endtask

    task automatic load_store_program(input logic [31:0] e0, input logic [31:0] e1,
                                      input logic [31:0] e2);
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0] = itype(6'h08, 5'd0, 5'd8, 16'd5);       // addi t0,zero,5
        rom[1] = itype(6'h08, 5'd0, 5'd9, 16'd9);       // addi t1,zero,9
        rom[2] = itype(6'h2b, 5'd0, 5'd8, 16'd0);       // sw t0,0(zero)
        rom[3] = itype(6'h2b, 5'd0, 5'd9, 16'd4);       // sw t1,4(zero)
        rom[4] = itype(6'h23, 5'd0, 5'd8, 16'd4);       // lw t0,4(zero)
        rom[5] = itype(6'h04, 5'd0, 5'd0, 16'hffff);    // halt loop
        tbl_kind[0] = 1'b1; tbl_addr[0] = 32'd0; tbl_exp[0] = e0;
        tbl_kind[1] = 1'b1; tbl_addr[1] = 32'd1; tbl_exp[1] = e1;
        tbl_kind[2] = 1'b0; tbl_addr[2] = 32'd8; tbl_exp[2] = e2;
        tbl_kind[3] = 1'b0; tbl_addr[3] = 32'd0; tbl_exp[3] = 32'd0;
    endtask

    // ---------------- scoreboard ------------------------------------------
    typedef struct {
        logic [CHK_W:0]   fc;
        logic [CHK_W-1:0] idx;
        logic [31:0]      obs;
        logic             pass;
    } res_t;
    typedef struct {
        logic [IMEM_AW-1:0] a;
        logic [31:0]        d;
    } wr_t;
    res_t res_q[$];
    wr_t  wr_q[$];

    // Clears the CPU model, queues expectations and pulses start. Returns at
    // the falling edge of cycle 1 after the start-sampling edge.
    task automatic kick(input res_t exp, input bit track_writes);
        @(negedge clock); model_clear = 1'b1;
        @(negedge clock); model_clear = 1'b0;
        if (track_writes)
            for (int i = 0; i < NUM_INSTR; i++) wr_q.push_back('{a: IMEM_AW'(i), d: rom[i]});
        res_q.push_back(exp);
        start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_done(input int n_in, output int n_out);
        int n = n_in;
        while (done !== 1'b1 && n < DONE_AT + 20) begin
            @(negedge clock); n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
        end
        n_out = n;
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({cpu_reset, busy, done, pass, bus.imem_we} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl: rst/busy/done/pass/we=%b required 10000",
                     {cpu_reset, busy, done, pass, bus.imem_we});
        end
        vectors++;
        if ({fail_count, first_fail_index, first_fail_observed} !== '0) begin
            miscompares++;
            $display("FAIL reset_results: fc=%0d idx=%0d obs=%0h required 0/0/0",
                     fail_count, first_fail_index, first_fail_observed);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_branch_load();
        res_t exp;
        wr_t  w;
        logic exp_we, exp_rst, exp_done;
        load_branch_program();
        kick('{fc: '0, idx: '0, obs: '0, pass: 1'b1}, 1'b1);
        for (int n = 1; n <= DONE_AT; n++) begin
            if (n > 1) @(negedge clock);
            exp_we   = (n <= NUM_INSTR);
            exp_rst  = !(n >= NUM_INSTR + 3 && n <= NUM_INSTR + 2 + RUN_CYCLES);
            exp_done = (n == DONE_AT);
            vectors++;
            if ({bus.imem_we, cpu_reset, done} !== {exp_we, exp_rst, exp_done}) begin
                miscompares++;
                $display("FAIL seq_cycle%0d: we/rst/done=%b required %b", n,
                         {bus.imem_we, cpu_reset, done}, {exp_we, exp_rst, exp_done});
            end
            if (bus.imem_we === 1'b1 && wr_q.size() > 0) begin
                w = wr_q.pop_front();
                vectors++;
                if (bus.imem_waddr !== w.a || bus.imem_wdata !== w.d) begin
                    miscompares++;
                    $display("FAIL imem_write: addr=%0d data=%h required addr=%0d data=%h",
                             bus.imem_waddr, bus.imem_wdata, w.a, w.d);
                end
            end
        end
        vectors++;
        if (wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL imem_write_count: %0d writes missing, required 0", wr_q.size());
            wr_q.delete();
        end
        exp = res_q.pop_front();
        vectors++;
        if ({fail_count, first_fail_index, first_fail_observed, pass} !==
            {exp.fc, exp.idx, exp.obs, exp.pass}) begin
            miscompares++;
            $display("FAIL branch_result: fc=%0d idx=%0d obs=%0d pass=%b required %0d/%0d/%0d/%b",
                     fail_count, first_fail_index, first_fail_observed, pass,
                     exp.fc, exp.idx, exp.obs, exp.pass);
        end
    endtask

    task automatic test_store(input string name, input logic [31:0] e1, input res_t want);
        res_t exp;
        int   n;
        load_store_program(32'd5, e1, 32'd9);
        kick(want, 1'b0);
        vectors++;
        if ({busy, done, pass, fail_count} !== {3'b100, {(CHK_W+1){1'b0}}}) begin
            miscompares++;
            $display("FAIL %s_start_clear: busy/done/pass=%b fc=%0d required 100/0",
                     name, {busy, done, pass}, fail_count);
        end
        wait_done(1, n);
        vectors++;
        if (n != DONE_AT) begin
            miscompares++;
            $display("FAIL %s_latency: done in cycle %0d, required %0d", name, n, DONE_AT);
        end
        exp = res_q.pop_front();
        vectors++;
        if ({fail_count, first_fail_index, first_fail_observed, pass} !==
            {exp.fc, exp.idx, exp.obs, exp.pass}) begin
            miscompares++;
            $display("FAIL %s_result: fc=%0d idx=%0d obs=%0d pass=%b required %0d/%0d/%0d/%b",
                     name, fail_count, first_fail_index, first_fail_observed, pass,
                     exp.fc, exp.idx, exp.obs, exp.pass);
        end
    endtask

    task automatic test_back_to_back();
        res_t exp;
        int   n;
        // Every entry wrong: count saturates at NUM_CHECKS, first fail is 0.
        load_store_program(32'd6, 32'd10, 32'd10);
        kick('{fc: 3'd3, idx: 2'd0, obs: 32'd5, pass: 1'b0}, 1'b0);
        wait_done(1, n);
        exp = res_q.pop_front();
        vectors++;
        if ({fail_count, first_fail_index, first_fail_observed, pass} !==
            {exp.fc, exp.idx, exp.obs, exp.pass}) begin
            miscompares++;
            $display("FAIL saturate_result: fc=%0d idx=%0d obs=%0d pass=%b required %0d/%0d/%0d/%b",
                     fail_count, first_fail_index, first_fail_observed, pass,
                     exp.fc, exp.idx, exp.obs, exp.pass);
        end
        repeat (3) @(negedge clock);
        vectors++;
        if (done !== 1'b1 || fail_count !== 3'd3) begin
            miscompares++;
            $display("FAIL done_hold: done=%b fc=%0d required 1/3", done, fail_count);
        end
        test_store("restart", 32'd9, '{fc: '0, idx: '0, obs: '0, pass: 1'b1});
    endtask

    task automatic test_start_ignored();
        res_t exp;
        int   n;
        load_store_program(32'd5, 32'd9, 32'd9);
        kick('{fc: '0, idx: '0, obs: '0, pass: 1'b1}, 1'b0);
        n = 1;
        while (n < NUM_INSTR + 8) begin @(negedge clock); n++; end
        start = 1'b1;
        @(negedge clock); n++; start = 1'b0;
        vectors++;
        if (cpu_reset !== 1'b0 || bus.imem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_run: rst=%b we=%b required 0/0", cpu_reset, bus.imem_we);
        end
        wait_done(n, n);
        vectors++;
        if (n != DONE_AT) begin
            miscompares++;
            $display("FAIL ignore_latency: done in cycle %0d, required %0d", n, DONE_AT);
        end
        exp = res_q.pop_front();
        vectors++;
        if ({fail_count, pass} !== {exp.fc, exp.pass}) begin
            miscompares++;
            $display("FAIL ignore_result: fc=%0d pass=%b required %0d/%b",
                     fail_count, pass, exp.fc, exp.pass);
        end
    endtask

    task automatic test_reset_midload();
        res_t exp;
        int   n;
        load_branch_program();
        kick('{fc: '0, idx: '0, obs: '0, pass: 1'b1}, 1'b0);
        repeat (4) @(negedge clock);
        vectors++;
        if (bus.imem_we !== 1'b1 || cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL midload_state: we=%b rst=%b required 1/1", bus.imem_we, cpu_reset);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({cpu_reset, busy, done, pass, bus.imem_we, fail_count} !== {5'b10000, {(CHK_W+1){1'b0}}}) begin
            miscompares++;
            $display("FAIL async_reset: rst/busy/done/pass/we=%b fc=%0d required 10000/0",
                     {cpu_reset, busy, done, pass, bus.imem_we}, fail_count);
        end
        void'(res_q.pop_front());
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        kick('{fc: '0, idx: '0, obs: '0, pass: 1'b1}, 1'b0);
        wait_done(1, n);
        vectors++;
        if (n != DONE_AT) begin
            miscompares++;
            $display("FAIL rerun_latency: done in cycle %0d, required %0d", n, DONE_AT);
        end
        exp = res_q.pop_front();
        vectors++;
        if ({fail_count, first_fail_index, first_fail_observed, pass} !==
            {exp.fc, exp.idx, exp.obs, exp.pass}) begin
            miscompares++;
            $display("FAIL rerun_result: fc=%0d idx=%0d obs=%0d pass=%b required %0d/%0d/%0d/%b",
                     fail_count, first_fail_index, first_fail_observed, pass,
                     exp.fc, exp.idx, exp.obs, exp.pass);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; rom[i] = '0; end
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < 4; i++) begin tbl_kind[i] = 1'b0; tbl_addr[i] = '0; tbl_exp[i] = '0; end
        pc = '0;
        test_reset();
        test_branch_load();
        test_store("store_pass", 32'd9, '{fc: '0, idx: '0, obs: '0, pass: 1'b1});
        test_store("store_fail", 32'd8, '{fc: 3'd1, idx: 2'd1, obs: 32'd9, pass: 1'b0});
        test_back_to_back();
        test_start_ignored();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
